sdrctrl_wb_arbiter: RTL

//  Two-master Wishbone arbiter that shares the single Wishbone slave port of the

---
 rtl/sdrctrl_wb_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/sdrctrl_wb_arbiter.sv
// Round-robin two-master Wishbone arbiter in front of the SDRAM controller slave port.
// The grant is registered; the slave bus is a combinational mux of the granted master.
module sdrctrl_wb_arbiter #(
    parameter int unsigned AW      = 26,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              sys_clk,
    input  logic              RESETN,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [AW-1:0]     m0_addr_i,
    input  logic [DW-1:0]     m0_dat_i,
    input  logic [DW/8-1:0]   m0_sel_i,
    input  logic [2:0]        m0_cti_i,
    output logic              m0_ack_o,
    output logic [DW-1:0]     m0_dat_o,
    output logic              m0_err_o,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [AW-1:0]     m1_addr_i,
    input  logic [DW-1:0]     m1_dat_i,
    input  logic [DW/8-1:0]   m1_sel_i,
    input  logic [2:0]        m1_cti_i,
    output logic              m1_ack_o,
    output logic [DW-1:0]     m1_dat_o,
    output logic              m1_err_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [AW-1:0]     wb_addr_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [DW-1:0]     wb_dat_i
);

    localparam int unsigned WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1, RELEASE} state_t;

    state_t         state_q, state_d;
    logic           prio_q, prio_d;
    logic [WDW-1:0] wdog_q, wdog_d;

    logic           sel_m1;
    logic           in_gnt;
    logic           cur_cyc, cur_stb;
    logic           expire;

    // Granted-master view, selected only by the registered state
    assign sel_m1  = (state_q == GNT1);
    assign in_gnt  = (state_q == GNT0) || (state_q == GNT1);
    assign cur_cyc = sel_m1 ? m1_cyc_i : m0_cyc_i;
    assign cur_stb = sel_m1 ? m1_stb_i : m0_stb_i;

    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            wdog_q  <= wdog_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        wdog_d    = '0;
        expire    = 1'b0;
        wb_cyc_o  = 1'b0;
        wb_stb_o  = 1'b0;
        wb_we_o   = 1'b0;
        wb_addr_o = '0;
        wb_dat_o  = '0;
        wb_sel_o  = '0;
        wb_cti_o  = '0;
        m0_ack_o  = 1'b0;
        m0_dat_o  = '0;
        m0_err_o  = 1'b0;
        m1_ack_o  = 1'b0;
        m1_dat_o  = '0;
        m1_err_o  = 1'b0;

        case (state_q)
            IDLE: begin
                if ((m0_cyc_i && m0_stb_i) && (m1_cyc_i && m1_stb_i)) begin
                    state_d = prio_q ? GNT1 : GNT0;
                end else if (m0_cyc_i && m0_stb_i) begin
                    state_d = GNT0;
                end else if (m1_cyc_i && m1_stb_i) begin
                    state_d = GNT1;
                end
            end
            GNT0, GNT1: begin
                // A cyc drop takes precedence over expiry; an ack clears the watchdog
                if (!cur_cyc) begin
                    state_d = RELEASE;
                    prio_d  = ~sel_m1;
                end else if (cur_stb && !wb_ack_i) begin
                    if (wdog_q == WDW'(TIMEOUT - 1)) begin
                        expire  = 1'b1;
                        state_d = RELEASE;
                        prio_d  = ~sel_m1;
                    end else begin
                        wdog_d = wdog_q + WDW'(1);
                    end
                end

                wb_cyc_o  = cur_cyc & ~expire;
                wb_stb_o  = cur_stb & ~expire;
                wb_we_o   = sel_m1 ? m1_we_i   : m0_we_i;
                wb_addr_o = sel_m1 ? m1_addr_i : m0_addr_i;
                wb_dat_o  = sel_m1 ? m1_dat_i  : m0_dat_i;
                wb_sel_o  = sel_m1 ? m1_sel_i  : m0_sel_i;
                wb_cti_o  = sel_m1 ? m1_cti_i  : m0_cti_i;
                if (sel_m1) begin
                    m1_ack_o = wb_ack_i;
                    m1_dat_o = wb_dat_i;
                    m1_err_o = expire;
                end else begin
                    m0_ack_o = wb_ack_i;
                    m0_dat_o = wb_dat_i;
                    m0_err_o = expire;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule
